// File: rtl/baud_switch_ctrl_pkg.sv
// Shared types and helpers for the baud-rate switch controller.
// Select encodings match the Baudrate generator; state encoding is private to the controller.
package baud_switch_ctrl_pkg;

    localparam logic [1:0] SEL_9600    = 2'b00;
    localparam logic [1:0] SEL_57600   = 2'b01;
    localparam logic [1:0] SEL_115200  = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SWITCH = 2'd3
    } state_e;

    // Counter must hold SETTLE_CYCLES-1 and DRAIN_TIMEOUT-1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/baud_switch_ctrl_timer.sv
// cycle_timer: loadable saturating up/down counter with a compare-to-terminal flag.
// Latency: load/step take effect on the next edge; term_o is combinational from the count.
// Backpressure: none; the owner decides each cycle whether to load, step or hold.
module cycle_timer #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          src_clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [W-1:0]  load_val_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic [W-1:0]  term_val_i,
    output logic          term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/baud_switch_ctrl.sv
// baud_switch_ctrl: owns the Baudrate prescaler select; drains the UART, switches, then settles.
// Latency: accept-to-baud_ok is 2 + SETTLE_CYCLES plus one cycle per busy DRAIN cycle.
// Backpressure: req_ready low outside IDLE; uart_hold keeps TX/RX from starting frames meanwhile.
module baud_switch_ctrl
    import baud_switch_ctrl_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 16,
    parameter int         DRAIN_TIMEOUT = 4096,
    parameter logic [1:0] DEFAULT_SEL   = SEL_9600
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       uart_hold,
    output logic [1:0] prescaler_sel,
    output logic       baud_ok,
    output logic       done,
    output logic       err
);

    localparam int            CW          = cnt_width(SETTLE_CYCLES, DRAIN_TIMEOUT);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] pend_sel_q, pend_sel_d;
    logic       boot_q, boot_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       idle_q, idle_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_inc;
    logic          tmr_dec;
    logic [CW-1:0] tmr_term_val;
    logic          tmr_term;

    // DRAIN counts up towards the timeout, SETTLE counts down towards zero.
    assign tmr_term_val = (state_q == ST_DRAIN) ? DRAIN_LAST : '0;

    cycle_timer #(
        .W       (CW),
        .RST_VAL (SETTLE_LOAD)
    ) u_timer (
        .src_clk    (src_clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .inc_i      (tmr_inc),
        .dec_i      (tmr_dec),
        .term_val_i (tmr_term_val),
        .term_o     (tmr_term)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pend_sel_d   = pend_sel_q;
        boot_d       = boot_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_inc      = 1'b0;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_sel == SEL_INVALID) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        pend_sel_d   = req_sel;
                        state_d      = ST_DRAIN;
                        tmr_load     = 1'b1;
                        tmr_load_val = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // An idle UART on the timeout cycle still completes the switch.
                if (!tx_busy && !rx_busy) begin
                    state_d = ST_SWITCH;
                end else if (tmr_term) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_SWITCH: begin
                sel_d        = pend_sel_q;
                state_d      = ST_SETTLE;
                tmr_load     = 1'b1;
                tmr_load_val = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (tmr_term) begin
                    state_d = ST_IDLE;
                    done_d  = !boot_q;
                    boot_d  = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SETTLE;
            sel_q      <= DEFAULT_SEL;
            pend_sel_q <= DEFAULT_SEL;
            boot_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pend_sel_q <= pend_sel_d;
            boot_q     <= boot_d;
            done_q     <= done_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end

    assign req_ready     = idle_q;
    assign baud_ok       = idle_q;
    assign uart_hold     = !idle_q;
    assign prescaler_sel = sel_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_baud_switch_ctrl.sv
// Bench for baud_switch_ctrl: two instances (default and short timeout/settle), directed
// scenarios plus randomized requests checked against a timing-arithmetic reference model.
module tb_baud_switch_ctrl;

    logic       src_clk;
    logic       rst_n;
    logic       req_valid     [2];
    logic [1:0] req_sel       [2];
    logic       tx_busy       [2];
    logic       rx_busy       [2];
    logic       req_ready     [2];
    logic       uart_hold     [2];
    logic [1:0] prescaler_sel [2];
    logic       baud_ok       [2];
    logic       done          [2];
    logic       err           [2];

    int passes = 0;
    int total  = 0;
    int fails  = 0;
    logic [1:0] cur [2];

    baud_switch_ctrl dut0 (
        .src_clk(src_clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_sel(req_sel[0]), .req_ready(req_ready[0]),
        .tx_busy(tx_busy[0]), .rx_busy(rx_busy[0]), .uart_hold(uart_hold[0]),
        .prescaler_sel(prescaler_sel[0]), .baud_ok(baud_ok[0]), .done(done[0]), .err(err[0])
    );

    baud_switch_ctrl #(.SETTLE_CYCLES(4), .DRAIN_TIMEOUT(8), .DEFAULT_SEL(2'b01)) dut1 (
        .src_clk(src_clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_sel(req_sel[1]), .req_ready(req_ready[1]),
        .tx_busy(tx_busy[1]), .rx_busy(rx_busy[1]), .uart_hold(uart_hold[1]),
        .prescaler_sel(prescaler_sel[1]), .baud_ok(baud_ok[1]), .done(done[1]), .err(err[1])
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic int s_of(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    function automatic int t_of(input int u);
        return (u == 0) ? 4096 : 8;
    endfunction

    function automatic logic [1:0] def_of(input int u);
        return (u == 0) ? 2'b00 : 2'b01;
    endfunction

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s u%0d t=%0t observed=%0h expected=%0h", tag, u, $time, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int u, input logic ok, input logic [1:0] sel,
                            input logic dn, input logic er);
        chk({tag, ".ready"}, u, {31'd0, req_ready[u]}, {31'd0, ok});
        chk({tag, ".baud_ok"}, u, {31'd0, baud_ok[u]}, {31'd0, ok});
        chk({tag, ".hold"}, u, {31'd0, uart_hold[u]}, {31'd0, !ok});
        chk({tag, ".sel"}, u, {30'd0, prescaler_sel[u]}, {30'd0, sel});
        chk({tag, ".done"}, u, {31'd0, done[u]}, {31'd0, dn});
        chk({tag, ".err"}, u, {31'd0, err[u]}, {31'd0, er});
    endtask

    // baud_ok must rise exactly SETTLE_CYCLES edges after release, without a done pulse.
    task automatic reset_seq();
        @(negedge src_clk);
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_sel[u] = 2'b00; tx_busy[u] = 1'b0; rx_busy[u] = 1'b0;
        end
        #1;
        for (int u = 0; u < 2; u++) chk_outs("in_reset", u, 1'b0, def_of(u), 1'b0, 1'b0);
        @(negedge src_clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge src_clk); #1;
            for (int u = 0; u < 2; u++) chk_outs("boot", u, (k >= s_of(u)), def_of(u), 1'b0, 1'b0);
        end
        for (int u = 0; u < 2; u++) cur[u] = def_of(u);
    endtask

    // Reference model: outcome decided from the request and the busy length d (edges with busy
    // sampled high after acceptance). Switch when d < T: select moves at E(d+2), ok at E(d+2+S).
    task automatic do_req(input int u, input logic [1:0] sel, input int d, input bit use_rx);
        int kind;
        int end_e;
        logic [1:0] old;
        old = cur[u];
        if (sel == 2'b11) kind = 0;
        else if (sel == old) kind = 1;
        else if (d < t_of(u)) kind = 2;
        else kind = 3;

        @(negedge src_clk);
        req_valid[u] = 1'b1;
        req_sel[u]   = sel;
        if (kind >= 2 && d > 0) begin
            if (use_rx) rx_busy[u] = 1'b1; else tx_busy[u] = 1'b1;
        end

        if (kind <= 1) begin
            @(posedge src_clk); #1;
            chk_outs(kind == 0 ? "invalid" : "same", u, 1'b1, old, kind == 1, kind == 0);
            @(negedge src_clk);
            req_valid[u] = 1'b0;
        end else begin
            end_e = (kind == 2) ? d + 2 + s_of(u) : t_of(u);
            for (int k = 0; k <= end_e; k++) begin
                @(posedge src_clk); #1;
                if (k < end_e)
                    chk_outs("busy_win", u, 1'b0, (kind == 2 && k >= d + 2) ? sel : old, 1'b0, 1'b0);
                else
                    chk_outs(kind == 2 ? "switch_end" : "timeout_end", u, 1'b1,
                             (kind == 2) ? sel : old, kind == 2, kind == 3);
                @(negedge src_clk);
                if (k == 0) begin
                    req_valid[u] = ($urandom_range(0, 1) == 1);
                    req_sel[u]   = 2'($urandom_range(0, 3));
                end
                if (k == end_e - 1) req_valid[u] = 1'b0;
                if (k == d || k == end_e) begin
                    tx_busy[u] = 1'b0; rx_busy[u] = 1'b0;
                end
            end
            if (kind == 2) cur[u] = sel;
        end
        @(posedge src_clk); #1;
        chk_outs("after", u, 1'b1, cur[u], 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_sel[u] = 2'b00; tx_busy[u] = 1'b0; rx_busy[u] = 1'b0;
        end
        reset_seq();

        // Reset in the middle of SETTLE of a switch to 01.
        @(negedge src_clk);
        req_valid[0] = 1'b1; req_sel[0] = 2'b01;
        @(posedge src_clk);
        @(negedge src_clk);
        req_valid[0] = 1'b0;
        repeat (7) @(posedge src_clk);
        #1;
        chk("midrst.pre_sel", 0, {30'd0, prescaler_sel[0]}, 32'd1);
        chk("midrst.pre_hold", 0, {31'd0, uart_hold[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.sel", 0, {30'd0, prescaler_sel[0]}, 32'd0);
        chk("midrst.hold", 0, {31'd0, uart_hold[0]}, 32'd1);
        chk("midrst.ok", 0, {31'd0, baud_ok[0]}, 32'd0);
        reset_seq();

        do_req(0, 2'b10, 0, 1'b0);      // idle switch, latency 18
        do_req(0, 2'b01, 50, 1'b0);     // tx busy 50 cycles, latency 68
        do_req(1, 2'b10, 100, 1'b1);    // rx stuck: timeout at 8
        do_req(1, 2'b00, 7, 1'b1);      // idle on the timeout cycle wins
        do_req(0, 2'b11, 0, 1'b0);      // invalid select
        do_req(0, cur[0], 0, 1'b0);     // same select
        do_req(1, 2'b11, 0, 1'b0);
        do_req(1, cur[1], 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int u;
            int d;
            u = $urandom_range(0, 1);
            if (u == 0) d = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 4);
            else d = $urandom_range(0, 12);
            do_req(u, 2'($urandom_range(0, 3)), d, ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
